// File: rtl/dm_system_bus_access.sv
// ---------------------------------------------------------------------------
// dm_system_bus_access
// System Bus Access engine of the RISC-V debug module. Turns debugger
// sbaddress/sbdata register events into single-beat transactions on a
// req/gnt/r_valid bus master port and returns read data, the next
// (optionally auto-incremented) sbaddress, busy status and error codes
// to the DM CSR block.
//
// Optional feature macro: DM_SBA_ALIGN_CHECK_EN
//   defined   - starts whose address is not naturally aligned to the access
//               size are rejected with sberror = 3 (the size error, code 4,
//               wins when both apply).
//   undefined - misaligned accesses go out as-is on the byte lanes the
//               address selects.
// ---------------------------------------------------------------------------
module dm_system_bus_access #(
  parameter int unsigned BusWidth = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dmactive_i,
  // bus master port
  output logic                  master_req_o,
  output logic                  master_we_o,
  output logic [BusWidth-1:0]   master_add_o,
  output logic [BusWidth-1:0]   master_wdata_o,
  output logic [BusWidth/8-1:0] master_be_o,
  input  logic                  master_gnt_i,
  input  logic                  master_r_valid_i,
  input  logic [BusWidth-1:0]   master_r_rdata_i,
  // debug CSR side
  input  logic [BusWidth-1:0]   sbaddress_i,
  output logic [BusWidth-1:0]   sbaddress_o,
  input  logic                  sbaddress_write_valid_i,
  input  logic                  sbreadonaddr_i,
  input  logic                  sbautoincrement_i,
  input  logic [2:0]            sbaccess_i,
  input  logic                  sbreadondata_i,
  input  logic [BusWidth-1:0]   sbdata_i,
  input  logic                  sbdata_read_valid_i,
  input  logic                  sbdata_write_valid_i,
  output logic [BusWidth-1:0]   sbdata_o,
  output logic                  sbdata_valid_o,
  output logic                  sbbusy_o,
  output logic                  sberror_valid_o,
  output logic [2:0]            sberror_o
);

  localparam int unsigned NumBytes = BusWidth / 8;
  localparam int unsigned AddrLsb  = $clog2(NumBytes);

  // Only 32- and 64-bit bus ports are supported.
  if (BusWidth != 32 && BusWidth != 64) begin : g_bad_bus_width
    $error("dm_system_bus_access: BusWidth must be 32 or 64");
  end

  typedef enum logic [2:0] {
    Idle,
    Read,
    Write,
    WaitRead,
    WaitWrite
  } state_e;

  state_e             state;
  logic               start_read;
  logic               start_write;
  logic               start_any;
  logic               size_err;
  logic               align_err;
  logic               issue;
  logic               complete;
  logic [AddrLsb-1:0] offset;

  assign offset   = sbaddress_i[AddrLsb-1:0];
  assign sbbusy_o = (state != Idle);

  // Decode start events in Idle; sbaddress writes with readonaddr win.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    start_read  = 1'b0;
    start_write = 1'b0;
    if (state == Idle && dmactive_i) begin
      if (sbaddress_write_valid_i && sbreadonaddr_i) begin
        start_read = 1'b1;
      end else if (sbdata_write_valid_i) begin
        start_write = 1'b1;
      end else if (sbdata_read_valid_i && sbreadondata_i) begin
        start_read = 1'b1;
      end
    end
  end

  assign start_any = start_read | start_write;
  assign size_err  = (sbaccess_i > 3'(AddrLsb));

`ifdef DM_SBA_ALIGN_CHECK_EN
  // Low address bits below the access size must be zero; only evaluated
  // meaningfully when the size itself is legal (sbaccess <= 3).
  logic [3:0] align_mask;
  assign align_mask = (4'd1 << sbaccess_i) - 4'd1;
  assign align_err  = |(sbaddress_i[2:0] & align_mask[2:0]);
`else
  assign align_err  = 1'b0;
`endif

  // Errors are reported combinationally in the start cycle and block the request.
  always_comb begin
    sberror_valid_o = 1'b0;
    sberror_o       = 3'd0;
    if (start_any && size_err) begin
      sberror_valid_o = 1'b1;
      sberror_o       = 3'd4;
    end else if (start_any && align_err) begin
      sberror_valid_o = 1'b1;
      sberror_o       = 3'd3;
    end
  end

  assign issue = start_any & ~size_err & ~align_err;

  // Main FSM; bus request and write enable are registered with the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    if (!rst_ni) begin
      state        <= Idle;
      master_req_o <= 1'b0;
      master_we_o  <= 1'b0;
    end else if (!dmactive_i) begin
      state        <= Idle;
      master_req_o <= 1'b0;
      master_we_o  <= 1'b0;
    end else begin
      unique case (state)
        Idle: begin
          if (issue) begin
            state        <= start_read ? Read : Write;
            master_req_o <= 1'b1;
            master_we_o  <= start_write;
          end
        end
        Read: begin
          if (master_gnt_i) begin
            state        <= WaitRead;
            master_req_o <= 1'b0;
          end
        end
        Write: begin
          if (master_gnt_i) begin
            state        <= WaitWrite;
            master_req_o <= 1'b0;
            master_we_o  <= 1'b0;
          end
        end
        WaitRead, WaitWrite: begin
          if (master_r_valid_i) begin
            state <= Idle;
          end
        end
        default: begin
          state        <= Idle;
          master_req_o <= 1'b0;
          master_we_o  <= 1'b0;
        end
      endcase
    end
  end

  // A response only counts while waiting for it and while the DM is active.
  assign complete = dmactive_i & master_r_valid_i &
                    ((state == WaitRead) | (state == WaitWrite));

  assign master_add_o   = sbaddress_i;
  assign master_wdata_o = sbdata_i << {offset, 3'b000};

  // Byte enables: (1 << sbaccess) lanes starting at the address offset,
  // clipped at the top of the bus word.
  always_comb begin
    master_be_o = '0;
    for (int i = 0; i < int'(NumBytes); i++) begin
      if (i >= int'(offset) && i < int'(offset) + (1 << sbaccess_i)) begin
        master_be_o[i] = 1'b1;
      end
    end
  end

  // Read data returned right-aligned in the response cycle.
  always_comb begin
    sbdata_valid_o = complete && (state == WaitRead);
    sbdata_o       = '0;
    if (sbdata_valid_o) begin
      sbdata_o = master_r_rdata_i >> {offset, 3'b000};
    end
  end

  // Next sbaddress: bumped by the access size only in the completing cycle.
  always_comb begin
    sbaddress_o = sbaddress_i;
    if (complete && sbautoincrement_i) begin
      sbaddress_o = sbaddress_i + (BusWidth'(1) << sbaccess_i);
    end
  end

endmodule

// File: tb/tb_dm_system_bus_access.sv
// ---------------------------------------------------------------------------
// tb_dm_system_bus_access
// Directed bench for dm_system_bus_access (BusWidth = 32). Inputs change just
// after the falling edge; outputs are sampled 1 ns later, well before the
// next rising edge.
// ---------------------------------------------------------------------------
module tb_dm_system_bus_access;

  localparam int BW = 32;

  logic          clk_i;
  logic          rst_ni;
  logic          dmactive_i;
  logic          master_req_o;
  logic          master_we_o;
  logic [BW-1:0] master_add_o;
  logic [BW-1:0] master_wdata_o;
  logic [3:0]    master_be_o;
  logic          master_gnt_i;
  logic          master_r_valid_i;
  logic [BW-1:0] master_r_rdata_i;
  logic [BW-1:0] sbaddress_i;
  logic [BW-1:0] sbaddress_o;
  logic          sbaddress_write_valid_i;
  logic          sbreadonaddr_i;
  logic          sbautoincrement_i;
  logic [2:0]    sbaccess_i;
  logic          sbreadondata_i;
  logic [BW-1:0] sbdata_i;
  logic          sbdata_read_valid_i;
  logic          sbdata_write_valid_i;
  logic [BW-1:0] sbdata_o;
  logic          sbdata_valid_o;
  logic          sbbusy_o;
  logic          sberror_valid_o;
  logic [2:0]    sberror_o;

  int n_cmp = 0;
  int n_bad = 0;

  dm_system_bus_access #(.BusWidth(BW)) dut (
    .clk_i                   (clk_i),
    .rst_ni                  (rst_ni),
    .dmactive_i              (dmactive_i),
    .master_req_o            (master_req_o),
    .master_we_o             (master_we_o),
    .master_add_o            (master_add_o),
    .master_wdata_o          (master_wdata_o),
    .master_be_o             (master_be_o),
    .master_gnt_i            (master_gnt_i),
    .master_r_valid_i        (master_r_valid_i),
    .master_r_rdata_i        (master_r_rdata_i),
    .sbaddress_i             (sbaddress_i),
    .sbaddress_o             (sbaddress_o),
    .sbaddress_write_valid_i (sbaddress_write_valid_i),
    .sbreadonaddr_i          (sbreadonaddr_i),
    .sbautoincrement_i       (sbautoincrement_i),
    .sbaccess_i              (sbaccess_i),
    .sbreadondata_i          (sbreadondata_i),
    .sbdata_i                (sbdata_i),
    .sbdata_read_valid_i     (sbdata_read_valid_i),
    .sbdata_write_valid_i    (sbdata_write_valid_i),
    .sbdata_o                (sbdata_o),
    .sbdata_valid_o          (sbdata_valid_o),
    .sbbusy_o                (sbbusy_o),
    .sberror_valid_o         (sberror_valid_o),
    .sberror_o               (sberror_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Move to the next cycle's drive point.
  task automatic next_cycle();
    @(negedge clk_i);
  endtask

  task automatic clear_events();
    sbaddress_write_valid_i = 1'b0;
    sbdata_write_valid_i    = 1'b0;
    sbdata_read_valid_i     = 1'b0;
    master_gnt_i            = 1'b0;
    master_r_valid_i        = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; dmactive_i = 1'b1; sbaddress_i = 32'h55; sbaccess_i = 3'd2;
    sbreadonaddr_i = 1'b0; sbreadondata_i = 1'b0; sbautoincrement_i = 1'b0;
    sbdata_i = '0; master_r_rdata_i = '0; clear_events();
    #12;
    n_cmp++; if (master_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %0h expected 0", master_req_o); end
    n_cmp++; if (master_we_o !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %0h expected 0", master_we_o); end
    n_cmp++; if (sbbusy_o !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0h expected 0", sbbusy_o); end
    n_cmp++; if (sbdata_valid_o !== 1'b0 || sbdata_o !== 32'h0) begin n_bad++; $display("FAIL rst_sbdata: got v=%0h d=%h expected v=0 d=0", sbdata_valid_o, sbdata_o); end
    n_cmp++; if (sberror_valid_o !== 1'b0 || sberror_o !== 3'd0) begin n_bad++; $display("FAIL rst_err: got v=%0h e=%0d expected 0/0", sberror_valid_o, sberror_o); end
    n_cmp++; if (sbaddress_o !== 32'h55) begin n_bad++; $display("FAIL rst_addr: got %h expected %h", sbaddress_o, 32'h55); end
    next_cycle(); rst_ni = 1'b1;
  endtask

  // Word read started by an sbaddress write, immediate grant, response next cycle.
  task automatic test_read_basic();
    next_cycle();
    sbaddress_i = 32'h1000; sbaccess_i = 3'd2; sbreadonaddr_i = 1'b1; sbaddress_write_valid_i = 1'b1;
    #1;
    n_cmp++; if (master_req_o !== 1'b0 || sbbusy_o !== 1'b0) begin n_bad++; $display("FAIL rd_n: got req=%0h busy=%0h expected 0/0", master_req_o, sbbusy_o); end
    next_cycle(); sbaddress_write_valid_i = 1'b0; master_gnt_i = 1'b1; #1;
    n_cmp++; if (master_req_o !== 1'b1 || master_we_o !== 1'b0 || sbbusy_o !== 1'b1) begin n_bad++; $display("FAIL rd_n1: got req=%0h we=%0h busy=%0h expected 1/0/1", master_req_o, master_we_o, sbbusy_o); end
    n_cmp++; if (master_be_o !== 4'hF || master_add_o !== 32'h1000) begin n_bad++; $display("FAIL rd_lanes: got be=%h add=%h expected f/00001000", master_be_o, master_add_o); end
    next_cycle(); master_gnt_i = 1'b0; master_r_valid_i = 1'b1; master_r_rdata_i = 32'hDEADBEEF; #1;
    n_cmp++; if (master_req_o !== 1'b0 || sbbusy_o !== 1'b1) begin n_bad++; $display("FAIL rd_n2: got req=%0h busy=%0h expected 0/1", master_req_o, sbbusy_o); end
    n_cmp++; if (sbdata_valid_o !== 1'b1 || sbdata_o !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data: got v=%0h d=%h expected 1/deadbeef", sbdata_valid_o, sbdata_o); end
    n_cmp++; if (sbaddress_o !== 32'h1000) begin n_bad++; $display("FAIL rd_noinc: got %h expected 00001000", sbaddress_o); end
    next_cycle(); master_r_valid_i = 1'b0; sbreadonaddr_i = 1'b0; #1;
    n_cmp++; if (sbbusy_o !== 1'b0 || sbdata_valid_o !== 1'b0) begin n_bad++; $display("FAIL rd_n3: got busy=%0h v=%0h expected 0/0", sbbusy_o, sbdata_valid_o); end
  endtask

  // Word write with autoincrement.
  task automatic test_write_autoinc();
    next_cycle();
    sbautoincrement_i = 1'b1; sbaccess_i = 3'd2; sbaddress_i = 32'h2000; sbdata_i = 32'h12345678; sbdata_write_valid_i = 1'b1;
    #1;
    n_cmp++; if (sbaddress_o !== 32'h2000) begin n_bad++; $display("FAIL wr_addr_start: got %h expected 00002000", sbaddress_o); end
    next_cycle(); sbdata_write_valid_i = 1'b0; master_gnt_i = 1'b1; #1;
    n_cmp++; if (master_req_o !== 1'b1 || master_we_o !== 1'b1) begin n_bad++; $display("FAIL wr_req: got req=%0h we=%0h expected 1/1", master_req_o, master_we_o); end
    n_cmp++; if (master_wdata_o !== 32'h12345678 || master_be_o !== 4'hF) begin n_bad++; $display("FAIL wr_lanes: got wdata=%h be=%h expected 12345678/f", master_wdata_o, master_be_o); end
    next_cycle(); master_gnt_i = 1'b0; master_r_valid_i = 1'b1; #1;
    n_cmp++; if (sbaddress_o !== 32'h2004) begin n_bad++; $display("FAIL wr_autoinc: got %h expected 00002004", sbaddress_o); end
    n_cmp++; if (sbdata_valid_o !== 1'b0) begin n_bad++; $display("FAIL wr_novalid: got %0h expected 0", sbdata_valid_o); end
    next_cycle(); master_r_valid_i = 1'b0; #1;
    n_cmp++; if (sbbusy_o !== 1'b0 || sbaddress_o !== 32'h2000) begin n_bad++; $display("FAIL wr_done: got busy=%0h addr=%h expected 0/00002000", sbbusy_o, sbaddress_o); end
    sbautoincrement_i = 1'b0;
  endtask

  // Byte write and byte read on the top lane.
  task automatic test_byte_lane();
    next_cycle();
    sbaccess_i = 3'd0; sbaddress_i = 32'h3003; sbdata_i = 32'hAB; sbdata_write_valid_i = 1'b1;
    next_cycle(); sbdata_write_valid_i = 1'b0; master_gnt_i = 1'b1; #1;
    n_cmp++; if (master_be_o !== 4'h8 || master_wdata_o !== 32'hAB000000) begin n_bad++; $display("FAIL byte_wr: got be=%h wdata=%h expected 8/ab000000", master_be_o, master_wdata_o); end
    next_cycle(); master_gnt_i = 1'b0; master_r_valid_i = 1'b1;
    next_cycle(); master_r_valid_i = 1'b0;
    sbreadondata_i = 1'b1; sbdata_read_valid_i = 1'b1;
    next_cycle(); sbdata_read_valid_i = 1'b0; master_gnt_i = 1'b1; #1;
    n_cmp++; if (master_req_o !== 1'b1 || master_we_o !== 1'b0 || master_be_o !== 4'h8) begin n_bad++; $display("FAIL byte_rd_req: got req=%0h we=%0h be=%h expected 1/0/8", master_req_o, master_we_o, master_be_o); end
    next_cycle(); master_gnt_i = 1'b0; master_r_valid_i = 1'b1; master_r_rdata_i = 32'hCD000000; #1;
    n_cmp++; if (sbdata_valid_o !== 1'b1 || sbdata_o !== 32'hCD) begin n_bad++; $display("FAIL byte_rd: got v=%0h d=%h expected 1/000000cd", sbdata_valid_o, sbdata_o); end
    next_cycle(); master_r_valid_i = 1'b0; sbreadondata_i = 1'b0;
  endtask

  // Oversized access on a 32-bit bus.
  task automatic test_size_error();
    next_cycle();
    sbaccess_i = 3'd3; sbaddress_i = 32'h1000; sbreadonaddr_i = 1'b1; sbaddress_write_valid_i = 1'b1; #1;
    n_cmp++; if (sberror_valid_o !== 1'b1 || sberror_o !== 3'd4) begin n_bad++; $display("FAIL size_err: got v=%0h e=%0d expected 1/4", sberror_valid_o, sberror_o); end
    next_cycle(); sbaddress_write_valid_i = 1'b0; sbreadonaddr_i = 1'b0; #1;
    n_cmp++; if (master_req_o !== 1'b0 || sbbusy_o !== 1'b0 || sberror_valid_o !== 1'b0) begin n_bad++; $display("FAIL size_after: got req=%0h busy=%0h err=%0h expected 0/0/0", master_req_o, sbbusy_o, sberror_valid_o); end
  endtask

  // Misaligned word at 0x1002: rejected with the check, else issued on lanes 2-3.
  task automatic test_misaligned();
    next_cycle();
    sbaccess_i = 3'd2; sbaddress_i = 32'h1002; sbdata_i = 32'h0000A5A5; sbdata_write_valid_i = 1'b1; #1;
`ifdef DM_SBA_ALIGN_CHECK_EN
    n_cmp++; if (sberror_valid_o !== 1'b1 || sberror_o !== 3'd3) begin n_bad++; $display("FAIL align_err: got v=%0h e=%0d expected 1/3", sberror_valid_o, sberror_o); end
    next_cycle(); sbdata_write_valid_i = 1'b0; #1;
    n_cmp++; if (master_req_o !== 1'b0 || sbbusy_o !== 1'b0) begin n_bad++; $display("FAIL align_noreq: got req=%0h busy=%0h expected 0/0", master_req_o, sbbusy_o); end
`else
    n_cmp++; if (sberror_valid_o !== 1'b0) begin n_bad++; $display("FAIL misal_noerr: got %0h expected 0", sberror_valid_o); end
    next_cycle(); sbdata_write_valid_i = 1'b0; master_gnt_i = 1'b1; #1;
    n_cmp++; if (master_req_o !== 1'b1 || master_be_o !== 4'hC || master_wdata_o !== 32'hA5A50000) begin n_bad++; $display("FAIL misal_req: got req=%0h be=%h wdata=%h expected 1/c/a5a50000", master_req_o, master_be_o, master_wdata_o); end
    next_cycle(); master_gnt_i = 1'b0; master_r_valid_i = 1'b1;
    next_cycle(); master_r_valid_i = 1'b0;
`endif
  endtask

  // Grant withheld for 5 cycles (with a stray r_valid), then DM deactivated.
  task automatic test_dmactive_abort();
    next_cycle();
    sbaccess_i = 3'd2; sbaddress_i = 32'h4000; sbreadonaddr_i = 1'b1; sbaddress_write_valid_i = 1'b1;
    next_cycle(); sbaddress_write_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      master_r_valid_i = (i == 2); master_r_rdata_i = 32'h77777777; #1;
      n_cmp++; if (master_req_o !== 1'b1 || sbdata_valid_o !== 1'b0) begin n_bad++; $display("FAIL hold_req[%0d]: got req=%0h v=%0h expected 1/0", i, master_req_o, sbdata_valid_o); end
      next_cycle();
    end
    master_r_valid_i = 1'b0; dmactive_i = 1'b0; #1;
    n_cmp++; if (master_req_o !== 1'b1) begin n_bad++; $display("FAIL abort_same: got req=%0h expected 1", master_req_o); end
    next_cycle(); #1;
    n_cmp++; if (master_req_o !== 1'b0 || sbbusy_o !== 1'b0 || sbdata_valid_o !== 1'b0) begin n_bad++; $display("FAIL abort_next: got req=%0h busy=%0h v=%0h expected 0/0/0", master_req_o, sbbusy_o, sbdata_valid_o); end
    dmactive_i = 1'b1; sbreadonaddr_i = 1'b0;
  endtask

  // Response arriving in WaitRead while the DM is inactive is discarded.
  task automatic test_dmactive_discard();
    next_cycle();
    sbautoincrement_i = 1'b1; sbaddress_i = 32'h5000; sbreadonaddr_i = 1'b1; sbaddress_write_valid_i = 1'b1;
    next_cycle(); sbaddress_write_valid_i = 1'b0; master_gnt_i = 1'b1;
    next_cycle(); master_gnt_i = 1'b0; dmactive_i = 1'b0; master_r_valid_i = 1'b1; master_r_rdata_i = 32'h11111111; #1;
    n_cmp++; if (sbdata_valid_o !== 1'b0 || sbaddress_o !== 32'h5000) begin n_bad++; $display("FAIL discard: got v=%0h addr=%h expected 0/00005000", sbdata_valid_o, sbaddress_o); end
    next_cycle(); master_r_valid_i = 1'b0; #1;
    n_cmp++; if (sbbusy_o !== 1'b0) begin n_bad++; $display("FAIL discard_idle: got busy=%0h expected 0", sbbusy_o); end
    dmactive_i = 1'b1; sbautoincrement_i = 1'b0; sbreadonaddr_i = 1'b0;
  endtask

  // Autoincrement at the top of the address space wraps to zero.
  task automatic test_wrap();
    next_cycle();
    sbautoincrement_i = 1'b1; sbaccess_i = 3'd2; sbaddress_i = 32'hFFFFFFFC; sbdata_i = 32'h1; sbdata_write_valid_i = 1'b1;
    next_cycle(); sbdata_write_valid_i = 1'b0; master_gnt_i = 1'b1;
    next_cycle(); master_gnt_i = 1'b0; master_r_valid_i = 1'b1; #1;
    n_cmp++; if (sbaddress_o !== 32'h0) begin n_bad++; $display("FAIL wrap: got %h expected 00000000", sbaddress_o); end
    next_cycle(); master_r_valid_i = 1'b0; sbautoincrement_i = 1'b0;
  endtask

  // Asynchronous reset in WaitRead clears outputs at once.
  task automatic test_reset_mid_read();
    next_cycle();
    sbaccess_i = 3'd2; sbaddress_i = 32'h6000; sbreadonaddr_i = 1'b1; sbaddress_write_valid_i = 1'b1;
    next_cycle(); sbaddress_write_valid_i = 1'b0; master_gnt_i = 1'b1;
    next_cycle(); master_gnt_i = 1'b0; master_r_valid_i = 1'b1; master_r_rdata_i = 32'h12121212;
    #1;
    n_cmp++; if (sbdata_valid_o !== 1'b1 || sbbusy_o !== 1'b1) begin n_bad++; $display("FAIL pre_rst: got v=%0h busy=%0h expected 1/1", sbdata_valid_o, sbbusy_o); end
    #1 rst_ni = 1'b0; #1;
    n_cmp++; if (sbbusy_o !== 1'b0 || master_req_o !== 1'b0 || master_we_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ctl: got busy=%0h req=%0h we=%0h expected 0/0/0", sbbusy_o, master_req_o, master_we_o); end
    n_cmp++; if (sbdata_valid_o !== 1'b0 || sbdata_o !== 32'h0) begin n_bad++; $display("FAIL mid_rst_data: got v=%0h d=%h expected 0/0", sbdata_valid_o, sbdata_o); end
    next_cycle(); master_r_valid_i = 1'b0; sbreadonaddr_i = 1'b0; rst_ni = 1'b1;
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_autoinc();
    test_byte_lane();
    test_size_error();
    test_misaligned();
    test_dmactive_abort();
    test_dmactive_discard();
    test_wrap();
    test_reset_mid_read();
    next_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
